// File: rtl/tft_power_sequencer.sv
// TFT panel power sequencer: panel reset, timing-generator gating, frame wait
// and PWM backlight ramping for both bring-up and shut-down.
module tft_power_sequencer #(
   parameter int pRstHoldCyc  = 1000,
   parameter int pRstRecovCyc = 5000,
   parameter int pFrameWait   = 2,
   parameter int pPwmBits     = 8,
   parameter int pRampStep    = 256
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iEnable,
   input  logic [pPwmBits-1:0] iBlDuty,
   input  logic                iVsync,
   output logic                oTftRst,
   output logic                oTimingEn,
   output logic                oBackLight,
   output logic                oReady,
   output logic [2:0]          oState
);

   typedef enum logic [2:0] {
      sOff        = 3'd0,
      sRstHold    = 3'd1,
      sRstRecov   = 3'd2,
      sTimingWait = 3'd3,
      sBlRamp     = 3'd4,
      sOn         = 3'd5,
      sBlDown     = 3'd6
   } stateT;

   localparam int CycMax = ((pRstHoldCyc > pRstRecovCyc) ? pRstHoldCyc : pRstRecovCyc) - 1;
   localparam int CycW   = (CycMax > 0) ? $clog2(CycMax + 1) : 1;
   localparam int EdgeW  = (pFrameWait > 1) ? $clog2(pFrameWait) : 1;
   localparam int StepW  = (pRampStep > 1) ? $clog2(pRampStep) : 1;

   localparam logic [CycW-1:0]     HoldLast  = CycW'(pRstHoldCyc - 1);
   localparam logic [CycW-1:0]     RecovLast = CycW'(pRstRecovCyc - 1);
   localparam logic [CycW-1:0]     CycSat    = CycW'(CycMax);
   localparam logic [EdgeW-1:0]    EdgeLast  = EdgeW'(pFrameWait - 1);
   localparam logic [StepW-1:0]    StepLast  = StepW'(pRampStep - 1);
   localparam logic [pPwmBits-1:0] PwmLast   = pPwmBits'((1 << pPwmBits) - 2);

   stateT               state;
   stateT               stateNext;
   logic [CycW-1:0]     cycCnt;
   logic [EdgeW-1:0]    edgeCnt;
   logic [StepW-1:0]    stepCnt;
   logic [pPwmBits-1:0] rDuty;
   logic [pPwmBits-1:0] rPwm;
   logic                rVsPrev;

   logic                vsFall;
   logic                blGate;
   logic [pPwmBits-1:0] dutyTarget;

   assign vsFall     = rVsPrev & ~iVsync;
   assign blGate     = state inside {sBlRamp, sOn, sBlDown};
   assign dutyTarget = (state == sBlDown) ? '0 : iBlDuty;
   assign oState     = state;

   // NOTE: default assignment first keeps this always_comb free of latches.
   always_comb begin
      stateNext = state;
      unique case (state)
         sOff:        if (iEnable) stateNext = sRstHold;
         sRstHold:    if (!iEnable) stateNext = sOff;
                      else if (cycCnt == HoldLast) stateNext = sRstRecov;
         sRstRecov:   if (!iEnable) stateNext = sOff;
                      else if (cycCnt == RecovLast) stateNext = sTimingWait;
         sTimingWait: if (!iEnable) stateNext = sOff;
                      else if (vsFall && edgeCnt == EdgeLast) stateNext = sBlRamp;
         sBlRamp:     if (!iEnable) stateNext = sBlDown;
                      else if (rDuty == iBlDuty) stateNext = sOn;
         sOn:         if (!iEnable) stateNext = sBlDown;
         sBlDown:     if (iEnable) stateNext = sBlRamp;
                      else if (rDuty == '0) stateNext = sOff;
         default:     stateNext = sOff;
      endcase
   end

   // NOTE: non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state      <= sOff;
         cycCnt     <= '0;
         edgeCnt    <= '0;
         stepCnt    <= '0;
         rDuty      <= '0;
         rPwm       <= '0;
         rVsPrev    <= 1'b1;
         oTftRst    <= 1'b0;
         oTimingEn  <= 1'b0;
         oBackLight <= 1'b0;
         oReady     <= 1'b0;
      end else begin
         state      <= stateNext;
         rVsPrev    <= iVsync;
         rPwm       <= (rPwm == PwmLast) ? '0 : rPwm + 1'b1;
         oTftRst    <= !(stateNext inside {sOff, sRstHold});
         oTimingEn  <= stateNext inside {sTimingWait, sBlRamp, sOn, sBlDown};
         oReady     <= (stateNext == sOn);
         oBackLight <= blGate && (rPwm < rDuty);

         // A state change wins over any pending step and restarts every timer.
         if (stateNext != state) begin
            cycCnt  <= '0;
            edgeCnt <= '0;
            stepCnt <= '0;
         end else begin
            unique case (state)
               sRstHold, sRstRecov: begin
                  if (cycCnt != CycSat) cycCnt <= cycCnt + 1'b1;
               end
               sTimingWait: begin
                  if (vsFall && edgeCnt != EdgeLast) edgeCnt <= edgeCnt + 1'b1;
               end
               sBlRamp, sOn, sBlDown: begin
                  if (rDuty == dutyTarget) begin
                     stepCnt <= '0;
                  end else if (stepCnt == StepLast) begin
                     stepCnt <= '0;
                     rDuty   <= (rDuty < dutyTarget) ? rDuty + 1'b1 : rDuty - 1'b1;
                  end else begin
                     stepCnt <= stepCnt + 1'b1;
                  end
               end
               default: ;
            endcase
         end

         if (state == sOff) rDuty <= '0;
      end
   end

endmodule

// File: tb/tb_tft_power_sequencer.sv
// Scoreboard bench for tft_power_sequencer: a timestamp-based reference model
// predicts every output cycle; a negedge monitor pops and compares.
module tb_tft_power_sequencer;

   localparam int HoldCyc   = 4;
   localparam int RecovCyc  = 6;
   localparam int FrameWait = 2;
   localparam int RampStep  = 2;
   localparam int PwmBits   = 4;
   localparam int PwmPeriod = (1 << PwmBits) - 1;

   localparam int OFF = 0, RST_HOLD = 1, RST_RECOV = 2, TIMING_WAIT = 3;
   localparam int BL_RAMP = 4, ON = 5, BL_DOWN = 6;

   logic               iClk = 1'b0;
   logic               iRst = 1'b0;
   logic               iEnable = 1'b0;
   logic [PwmBits-1:0] iBlDuty = '0;
   logic               iVsync = 1'b1;
   logic               oTftRst, oTimingEn, oBackLight, oReady;
   logic [2:0]         oState;

   tft_power_sequencer #(
      .pRstHoldCyc (HoldCyc),
      .pRstRecovCyc(RecovCyc),
      .pFrameWait  (FrameWait),
      .pPwmBits    (PwmBits),
      .pRampStep   (RampStep)
   ) dut (
      .iClk      (iClk),
      .iRst      (iRst),
      .iEnable   (iEnable),
      .iBlDuty   (iBlDuty),
      .iVsync    (iVsync),
      .oTftRst   (oTftRst),
      .oTimingEn (oTimingEn),
      .oBackLight(oBackLight),
      .oReady    (oReady),
      .oState    (oState)
   );

   always #5 iClk = ~iClk;

   typedef struct packed {
      logic       tftRst;
      logic       timingEn;
      logic       backLight;
      logic       ready;
      logic [2:0] state;
   } obsT;

   obsT sbQ[$];
   int  vectors = 0;
   int  miscompares = 0;

   // Reference model: phase, edge timestamps and duty as plain integers.
   int mState = OFF;
   int mNow = 0, mEntry = 0, mRef = 0, mEdges = 0, mDuty = 0, mPwmK = 0;
   bit mPrevVs = 1'b1;

   function automatic obsT observed();
      return {oTftRst, oTimingEn, oBackLight, oReady, oState};
   endfunction

   task automatic enter(input int s);
      mState = s;
      mEntry = mNow;
      mRef   = mNow;
      mEdges = 0;
   endtask

   task automatic rampToward(input int target);
      if (mNow - mRef == RampStep) begin
         mDuty += (target > mDuty) ? 1 : -1;
         mRef = mNow;
      end
   endtask

   task automatic modelStep(output obsT e);
      int preState, preDuty, prePwm, target;
      bit fall;
      preState = mState;
      preDuty  = mDuty;
      prePwm   = mPwmK % PwmPeriod;
      if (!iRst) begin
         mState = OFF; mNow = 0; mEntry = 0; mRef = 0; mEdges = 0;
         mDuty = 0; mPwmK = 0; mPrevVs = 1'b1;
         e = '0;
      end else begin
         mNow++;
         mPwmK++;
         fall    = mPrevVs && !iVsync;
         mPrevVs = iVsync;
         target  = int'(iBlDuty);
         case (mState)
            OFF: begin
               mDuty = 0;
               if (iEnable) enter(RST_HOLD);
            end
            RST_HOLD: begin
               if (!iEnable) enter(OFF);
               else if (mNow - mEntry == HoldCyc) enter(RST_RECOV);
            end
            RST_RECOV: begin
               if (!iEnable) enter(OFF);
               else if (mNow - mEntry == RecovCyc) enter(TIMING_WAIT);
            end
            TIMING_WAIT: begin
               if (!iEnable) enter(OFF);
               else if (fall) begin
                  mEdges++;
                  if (mEdges == FrameWait) enter(BL_RAMP);
               end
            end
            BL_RAMP: begin
               if (!iEnable) enter(BL_DOWN);
               else if (mDuty == target) enter(ON);
               else rampToward(target);
            end
            ON: begin
               if (!iEnable) enter(BL_DOWN);
               else if (mDuty == target) mRef = mNow;
               else rampToward(target);
            end
            BL_DOWN: begin
               if (iEnable) enter(BL_RAMP);
               else if (mDuty == 0) enter(OFF);
               else rampToward(0);
            end
            default: enter(OFF);
         endcase
         e.state     = 3'(mState);
         e.tftRst    = !(mState == OFF || mState == RST_HOLD);
         e.timingEn  = mState inside {TIMING_WAIT, BL_RAMP, ON, BL_DOWN};
         e.ready     = (mState == ON);
         e.backLight = (preState inside {BL_RAMP, ON, BL_DOWN}) && (prePwm < preDuty);
      end
   endtask

   task automatic tick();
      obsT e;
      @(posedge iClk);
      modelStep(e);
      sbQ.push_back(e);
      #1;
      iVsync = ($urandom_range(0, 2) != 0);
   endtask

   task automatic expectReached(input bit ok, input string what);
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: model state %0d duty %0d, condition not reached in budget", what, mState, mDuty);
      end
   endtask

   task automatic runUntil(input int st, input int cap, input string what);
      int n = 0;
      while (mState != st && n < cap) begin
         tick();
         n++;
      end
      expectReached(mState == st, what);
   endtask

   task automatic asyncResetCheck();
      obsT got;
      @(negedge iClk);
      #1;
      iRst = 1'b0;
      #1;
      got = observed();
      vectors++;
      if (got !== '0) begin
         miscompares++;
         $display("FAIL asyncReset: got %b, expected %b", got, 7'b0);
      end
      tick();
      tick();
      iEnable = 1'b1;
      iRst    = 1'b1;
   endtask

   always @(negedge iClk) begin
      obsT e, got;
      if (sbQ.size() != 0) begin
         e   = sbQ.pop_front();
         got = observed();
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL outputs @%0t: got tftRst=%b timingEn=%b bl=%b ready=%b state=%0d, expected tftRst=%b timingEn=%b bl=%b ready=%b state=%0d",
                     $time, got.tftRst, got.timingEn, got.backLight, got.ready, got.state,
                     e.tftRst, e.timingEn, e.backLight, e.ready, e.state);
         end
      end
   end

   initial begin
      repeat (3) tick();
      iRst = 1'b1;
      tick();

      // Full bring-up to full duty, then track down to 5, then shut down.
      iEnable = 1'b1;
      iBlDuty = PwmBits'(15);
      runUntil(ON, 200, "bringUp");
      repeat (20) tick();
      iBlDuty = PwmBits'(5);
      repeat (30) tick();
      iEnable = 1'b0;
      runUntil(OFF, 100, "shutDown");
      repeat (3) tick();

      // Abort during the frame wait after one vsync edge, then restart at zero duty.
      iEnable = 1'b1;
      iBlDuty = '0;
      for (int n = 0; n < 300 && !(mState == TIMING_WAIT && mEdges == 1); n++) tick();
      expectReached(mState == TIMING_WAIT && mEdges == 1, "oneEdgeInWait");
      iEnable = 1'b0;
      tick();
      expectReached(mState == OFF, "abortToOff");
      tick();
      iEnable = 1'b1;
      runUntil(ON, 300, "restartZeroDuty");

      // Re-enable during ramp-down: ramp resumes from the current duty.
      iBlDuty = PwmBits'(15);
      for (int n = 0; n < 100 && mDuty != 15; n++) tick();
      expectReached(mDuty == 15, "rampTo15");
      iEnable = 1'b0;
      for (int n = 0; n < 100 && !(mState == BL_DOWN && mDuty == 8); n++) tick();
      expectReached(mState == BL_DOWN && mDuty == 8, "downTo8");
      iBlDuty = PwmBits'(12);
      iEnable = 1'b1;
      runUntil(ON, 100, "resumeTo12");
      repeat (5) tick();

      // Asynchronous reset in the middle of a ramp, then restart.
      iEnable = 1'b0;
      runUntil(OFF, 100, "offBeforeReset");
      iEnable = 1'b1;
      iBlDuty = PwmBits'(15);
      runUntil(BL_RAMP, 300, "reachRamp");
      repeat (5) tick();
      asyncResetCheck();
      runUntil(ON, 300, "afterReset");

      // Random enable/duty traffic.
      for (int n = 0; n < 1500; n++) begin
         tick();
         if ($urandom_range(0, 59) == 0) iEnable = ~iEnable;
         if ($urandom_range(0, 39) == 0) iBlDuty = PwmBits'($urandom);
      end

      iEnable = 1'b0;
      runUntil(OFF, 200, "finalOff");
      repeat (2) tick();
      @(negedge iClk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tft_power_sequencer.md
Name: tft_power_sequencer

Overview:
Controller that sequences TFT panel bring-up and shut-down around the display timing generator and output pins. It drives the panel reset line, gates the timing generator, waits a programmable number of frames, then ramps a PWM backlight to a target duty. On disable it ramps the backlight down before gating timing and re-asserting panel reset. It sits between system control and the TFT block.

Parameters:
pRstHoldCyc, 1000, cycles oTftRst held low after iEnable rises (>=1)
pRstRecovCyc, 5000, cycles after oTftRst release before oTimingEn asserts (>=1)
pFrameWait, 2, iVsync falling edges counted with timing enabled before backlight ramp (>=1)
pPwmBits, 8, backlight duty/PWM counter width
pRampStep, 256, cycles per +/-1 duty step during ramps (>=1)

Ports:
iClk  input  1  pixel/system clock; all logic on rising edge
iRst  input  1  asynchronous active-low reset
iEnable  input  1  level request: 1 = panel on, 0 = panel off
iBlDuty  input  pPwmBits  target backlight duty; sampled every cycle
iVsync  input  1  active-low vsync from timing generator (iClk domain)
oTftRst  output  1  active-low panel reset
oTimingEn  output  1  enable for timing generator
oBackLight  output  1  PWM backlight drive
oReady  output  1  high only in ON state
oState  output  3  current FSM state encoding (debug)

Behaviour:
- Reset (iRst=0, async): state OFF; oTftRst=0, oTimingEn=0, oBackLight=0, oReady=0, oState=0; duty register rDuty=0; all counters 0; vsync edge register=1.
- All outputs are registered. A state change takes effect on outputs the cycle after the transition condition is sampled.
- Encodings: OFF=0, RST_HOLD=1, RST_RECOV=2, TIMING_WAIT=3, BL_RAMP=4, ON=5, BL_DOWN=6.
- OFF: oTftRst=0, oTimingEn=0, rDuty=0. iEnable=1 -> RST_HOLD, cycle counter cleared.
- RST_HOLD: oTftRst=0. Stays exactly pRstHoldCyc cycles -> RST_RECOV.
- RST_RECOV: oTftRst=1, oTimingEn=0. Stays pRstRecovCyc cycles -> TIMING_WAIT.
- TIMING_WAIT: oTftRst=1, oTimingEn=1. Counts iVsync falling edges (prev=1, cur=0). On the pFrameWait-th edge -> BL_RAMP.
- BL_RAMP: every pRampStep cycles rDuty moves one step toward iBlDuty (up or down). When rDuty==iBlDuty -> ON. If iBlDuty==0 on entry, go to ON after one cycle.
- ON: oReady=1. rDuty keeps tracking iBlDuty at the same ramp rate; there is no step jump.
- BL_DOWN: rDuty decrements 1 per pRampStep cycles. When rDuty==0 -> OFF. oTimingEn stays 1 until OFF.
- Disable: iEnable=0 in RST_HOLD, RST_RECOV or TIMING_WAIT -> OFF next cycle, with no ramp. iEnable=0 in BL_RAMP or ON -> BL_DOWN. iEnable=1 in BL_DOWN -> BL_RAMP, continuing from the current rDuty.
- PWM: free-running counter rPwm counts 0..2^pPwmBits-2 and wraps, giving a period of 2^pPwmBits-1 cycles. oBackLight = (rPwm < rDuty). rDuty=0 -> constant 0. rDuty=2^pPwmBits-1 -> constant 1. oBackLight is forced to 0 in every state except BL_RAMP, ON and BL_DOWN.
- Ramp step timer resets on each state entry. When iEnable changes and a step boundary fall in the same cycle, the state transition takes priority and no step is applied.
- All counters are sized for their parameter and saturate; none may wrap within a state.

Test Plan:
- Params pRstHoldCyc=4, pRstRecovCyc=6, pFrameWait=2, pRampStep=2, pPwmBits=4. Release iRst, iEnable=1, iBlDuty=15 -> oTftRst low 4 cycles, then high; oTimingEn rises 6 cycles later; after 2 iVsync falls, rDuty ramps 0..15 in 30 cycles; oReady=1; oBackLight constant 1.
- In ON, change iBlDuty 15->5 -> rDuty falls 1 per 2 cycles, reaching 5 after 20 cycles; oBackLight high 5 of every 15 cycles; oReady stays 1.
- Drop iEnable in ON with rDuty=5 -> BL_DOWN; oBackLight duty falls to 0 in 10 cycles; then OFF: oTimingEn=0, oTftRst=0, oReady=0.
- Drop iEnable during TIMING_WAIT after 1 vsync edge -> OFF next cycle. Re-enable -> full sequence restarts, including 4-cycle reset hold and edge count from 0.
- Re-assert iEnable in BL_DOWN at rDuty=8 with iBlDuty=12 -> BL_RAMP; rDuty goes 8->12 with no drop to 0; oTftRst never goes low.
- Assert iRst low mid-BL_RAMP -> same cycle (async): all outputs 0, oState=0. After release with iEnable=1 -> sequence restarts from RST_HOLD.
